seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/hex2seg_dec.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the 7-segment scan controller.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_OFF = 7'h7F;

  // Active-low segment code, bit 0 = segment a.
  function automatic seg7_t hex2seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      4'hB:    return 7'h03;
      4'hC:    return 7'h46;
      4'hD:    return 7'h21;
      4'hE:    return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/hex2seg_dec.sv
// Combinational 4-bit hex to active-low 7-segment decoder for the selected digit.
module hex2seg_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg7_t      seg_o
);

  assign seg_o = hex2seg(nib_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous double buffering.
// Define SEG7_SCAN_BLINK_EN to build the frame-based blink counter.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NDIG     = 8,
  parameter int SCAN_DIV = 131072,
  parameter int BLINK_W  = 5
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp_in,
  input  logic [NDIG-1:0]   blank_in,
  input  logic              lz_en,
  input  logic [NDIG-1:0]   blink_mask,
  output logic [6:0]        a2g,
  output logic [NDIG-1:0]   an,
  output logic              dp,
  output logic              upd_done
);

  localparam int IDX_W = $clog2(NDIG);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tick, frame_end;
  logic              pend_q, pend_d;
  logic              upd_q, upd_d;
  logic [4*NDIG-1:0] pend_val_q, act_val_q;
  logic [NDIG-1:0]   pend_dp_q, pend_blank_q, act_dp_q, act_blank_q;
  logic [NDIG-1:0]   an_q, an_d;
  seg7_t             a2g_q, a2g_d;
  logic              dp_q, dp_d;

  logic [3:0]        nib [NDIG];
  logic [3:0]        sel_nib;
  seg7_t             dec_seg;
  logic [NDIG-1:0]   supp_vec, blink_vec, dark_vec;
  logic              zrun;

  assign tick      = (presc_q == PRE_LAST);
  assign frame_end = tick && (idx_q == IDX_LAST);

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
    assign nib[gi]      = act_val_q[4*gi +: 4];
    assign dark_vec[gi] = act_blank_q[gi] | supp_vec[gi] | blink_vec[gi];
  end

  // Walk down from the most significant digit; digit 0 is never suppressed.
  always_comb begin
    supp_vec = '0;
    zrun     = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zrun        = zrun & (nib[i] == 4'h0);
      supp_vec[i] = lz_en & zrun;
    end
  end

`ifdef SEG7_SCAN_BLINK_EN
  logic [BLINK_W:0] blink_q, blink_d;

  assign blink_d   = frame_end ? blink_q + 1'b1 : blink_q;
  assign blink_vec = blink_mask & {NDIG{blink_q[BLINK_W]}};

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) blink_q <= '0;
    else        blink_q <= blink_d;
  end
`else
  logic unused_blink;

  assign unused_blink = (^blink_mask) ^ (BLINK_W > 0);
  assign blink_vec    = '0;
`endif

  assign sel_nib = nib[idx_q];

  hex2seg_dec u_dec (
    .nib_i (sel_nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    // A load on the boundary cycle re-arms pending with the new data.
    pend_d  = load | (pend_q & ~frame_end);
    upd_d   = frame_end & pend_q;
    an_d    = ~(NDIG'(1) << idx_q);
    a2g_d   = dark_vec[idx_q] ? SEG_OFF : dec_seg;
    dp_d    = ~act_dp_q[idx_q];
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      upd_q        <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      an_q         <= '1;
      a2g_q        <= SEG_OFF;
      dp_q         <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      upd_q   <= upd_d;
      an_q    <= an_d;
      a2g_q   <= a2g_d;
      dp_q    <= dp_d;
      if (load) begin
        pend_val_q   <= value;
        pend_dp_q    <= dp_in;
        pend_blank_q <= blank_in;
      end
      if (frame_end && pend_q) begin
        act_val_q   <= pend_val_q;
        act_dp_q    <= pend_dp_q;
        act_blank_q <= pend_blank_q;
      end
    end
  end

  assign a2g      = a2g_q;
  assign an       = an_q;
  assign dp       = dp_q;
  assign upd_done = upd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl at NDIG=4, SCAN_DIV=4, BLINK_W=1.
// Blink expectations follow SEG7_SCAN_BLINK_EN when it is defined for the build.
module tb_seg7_scan_ctrl;

  logic        clk, clr_n, load, lz_en;
  logic [15:0] value;
  logic [3:0]  dp_in, blank_in, blink_mask, an;
  logic [6:0]  a2g;
  logic        dp, upd_done;

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dpi;
    logic [3:0]  blk;
    logic        lz;
    logic [27:0] seg;   // {digit3, digit2, digit1, digit0}
    logic [3:0]  dpo;   // expected active-low dp per digit
  } vec_t;

  vec_t vecs [10];

  seg7_scan_ctrl #(.NDIG(4), .SCAN_DIV(4), .BLINK_W(1)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lz_en      (lz_en),
    .blink_mask (blink_mask),
    .a2g        (a2g),
    .an         (an),
    .dp         (dp),
    .upd_done   (upd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failed=%0d", nfail);
    $fatal(1, "watchdog");
  end

  // Sixteen samples starting one cycle after the index change: four per digit.
  task automatic check_frame(input logic [27:0] es, input logic [3:0] edp,
                             input logic eu_end, input string nm);
    int errs = 0;
    for (int k = 0; k < 16; k++) begin
      int         d;
      logic [3:0] ean;
      logic [6:0] eseg;
      logic       eu;
      @(negedge clk);
      d    = k / 4;
      ean  = ~(4'b0001 << d);
      eseg = es[d*7 +: 7];
      eu   = (k == 15) ? eu_end : 1'b0;
      ntests++;
      if (an !== ean || a2g !== eseg || dp !== edp[d] || upd_done !== eu) begin
        nfail++;
        errs++;
        $display("FAIL %s slot %0d: got an=%b a2g=%h dp=%b upd=%b, expected an=%b a2g=%h dp=%b upd=%b",
                 nm, k, an, a2g, dp, upd_done, ean, eseg, edp[d], eu);
      end
    end
    $display("[TB] frame %s: digits %h %h %h %h, %0d slot errors", nm,
             es[27:21], es[20:14], es[13:7], es[6:0], errs);
  endtask

  task automatic wait_upd(input string nm);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = (upd_done === 1'b1);
    end
    ntests++;
    if (!seen) begin
      nfail++;
      $display("FAIL %s upd_done: got no pulse in 40 cycles, expected a pulse", nm);
    end
  endtask

  task automatic check_reset(input string nm);
    ntests++;
    if (an !== 4'hF || a2g !== 7'h7F || dp !== 1'b1 || upd_done !== 1'b0) begin
      nfail++;
      $display("FAIL %s: got an=%b a2g=%h dp=%b upd=%b, expected an=1111 a2g=7f dp=1 upd=0",
               nm, an, a2g, dp, upd_done);
    end else
      $display("[TB] %s: outputs idle", nm);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value    = v;
    dp_in    = d;
    blank_in = b;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  initial begin
    logic [6:0] d0;

    vecs[0] = '{16'hC0DE, 4'h0,    4'h0,    1'b0, {7'h46, 7'h40, 7'h21, 7'h06}, 4'hF};
    vecs[1] = '{16'h0030, 4'h0,    4'h0,    1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'hF};
    vecs[2] = '{16'h0000, 4'h0,    4'h0,    1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
    vecs[3] = '{16'h0000, 4'b0100, 4'h0,    1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1011};
    vecs[4] = '{16'h8765, 4'b1001, 4'b0010, 1'b0, {7'h00, 7'h78, 7'h7F, 7'h12}, 4'b0110};
    vecs[5] = '{16'h0B0C, 4'h0,    4'h0,    1'b1, {7'h7F, 7'h03, 7'h40, 7'h46}, 4'hF};
    vecs[6] = '{16'h3D9E, 4'h0,    4'h0,    1'b0, {7'h30, 7'h21, 7'h10, 7'h06}, 4'hF};
    vecs[7] = '{16'h4000, 4'h0,    4'h0,    1'b1, {7'h19, 7'h40, 7'h40, 7'h40}, 4'hF};
    vecs[8] = '{16'h0600, 4'h0,    4'h0,    1'b1, {7'h7F, 7'h02, 7'h40, 7'h40}, 4'hF};
    vecs[9] = '{16'h0000, 4'h0,    4'h0,    1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF};

    clr_n = 1'b0; load = 1'b0; lz_en = 1'b0; value = '0;
    dp_in = '0; blank_in = '0; blink_mask = '0;

    // Reset state, then free-running scan of zeros.
    repeat (3) @(negedge clk);
    check_reset("reset");
    clr_n = 1'b1;
    check_frame({4{7'h40}}, 4'hF, 1'b0, "idle_scan");

    // Mid-frame load: old digits hold until the boundary.
    repeat (2) @(negedge clk);
    do_load(16'h12AF, 4'h0, 4'h0);
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
        @(negedge clk);
        if (upd_done === 1'b1) seen = 1'b1;
        else begin
          ntests++;
          if (a2g !== 7'h40 || dp !== 1'b1) begin
            nfail++;
            $display("FAIL hold_before_boundary: got a2g=%h dp=%b, expected a2g=40 dp=1", a2g, dp);
          end
        end
      end
      ntests++;
      if (!seen) begin
        nfail++;
        $display("FAIL hold upd_done: got no pulse in 40 cycles, expected a pulse");
      end
    end
    check_frame({7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 1'b0, "load_12AF");

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      lz_en = vecs[i].lz;
      do_load(vecs[i].val, vecs[i].dpi, vecs[i].blk);
      wait_upd($sformatf("vec%0d", i));
      check_frame(vecs[i].seg, vecs[i].dpo, 1'b0, $sformatf("vec%0d_%h", i, vecs[i].val));
    end

    // Two loads in one frame: last wins, one pulse.
    lz_en = 1'b0;
    do_load(16'h1111, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    do_load(16'h2222, 4'h0, 4'h0);
    wait_upd("double_load");
    check_frame({4{7'h24}}, 4'hF, 1'b0, "double_load_2222");

    // Load on the boundary cycle: old pending shows first, new one next frame.
    @(negedge clk);
    do_load(16'hA5A5, 4'h0, 4'h0);
    repeat (13) @(negedge clk);
    value = 16'h9876;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    ntests++;
    if (upd_done !== 1'b1) begin
      nfail++;
      $display("FAIL boundary_load upd_done: got %b, expected 1", upd_done);
    end
    check_frame({7'h08, 7'h12, 7'h08, 7'h12}, 4'hF, 1'b1, "boundary_A5A5");
    check_frame({7'h10, 7'h00, 7'h78, 7'h02}, 4'hF, 1'b0, "boundary_9876");

    // Reset with data pending discards it; blink windows follow from release.
    blink_mask = 4'b0001;
    do_load(16'h5555, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    clr_n = 1'b0;
    #2;
    check_reset("reset_pending");
    @(negedge clk);
    clr_n = 1'b1;
    for (int w = 0; w < 8; w++) begin
`ifdef SEG7_SCAN_BLINK_EN
      d0 = ((w % 4) >= 2) ? 7'h7F : 7'h40;
`else
      d0 = 7'h40;
`endif
      check_frame({7'h40, 7'h40, 7'h40, d0}, 4'hF, 1'b0, $sformatf("after_reset_w%0d", w));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
